// File: rtl/retire_rat_pkg.sv
// Shared types and sizing for the retirement register alias table.
package retire_rat_pkg;

    localparam int unsigned DISPATCH_WIDTH       = 2;
    localparam int unsigned PHYS_REGS            = 64;
    localparam int unsigned PHYS_REGS_ADDR_WIDTH = $clog2(PHYS_REGS);
    localparam int unsigned ARCH_REGS            = 32;
    localparam int unsigned ARCH_REG_WIDTH       = 5;
    localparam int unsigned PC_WIDTH             = 32;
    localparam int unsigned INSTRET_WIDTH        = 64;
    localparam int unsigned LANE_CNT_WIDTH       = $clog2(DISPATCH_WIDTH + 1);

    typedef logic [ARCH_REG_WIDTH-1:0]       arch_reg_t;
    typedef logic [PHYS_REGS_ADDR_WIDTH-1:0] phys_reg_t;
    typedef logic [PC_WIDTH-1:0]             pc_t;

    // One retiring instruction as presented by the reorder buffer commit port.
    typedef struct packed {
        logic      en;
        phys_reg_t phys_rd;
        arch_reg_t arch_rd;
        pc_t       pc;
    } commit_lane_t;

    // Number of set bits in a lane-enable vector.
    function automatic logic [LANE_CNT_WIDTH-1:0] popcount(input logic [DISPATCH_WIDTH-1:0] v);
        logic [LANE_CNT_WIDTH-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < int'(DISPATCH_WIDTH); i++) begin
            cnt = cnt + LANE_CNT_WIDTH'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/retire_rat.sv
// Retirement RAT: committed arch->phys map, superseded-register free, instret and last PC.
module retire_rat
    import retire_rat_pkg::*;
(
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic [DISPATCH_WIDTH-1:0]                           commit_en,
    input  logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] commit_phys_rd,
    input  logic [DISPATCH_WIDTH-1:0][ARCH_REG_WIDTH-1:0]       commit_arch_rd,
    input  logic [DISPATCH_WIDTH-1:0][PC_WIDTH-1:0]             commit_pc,
    output logic [DISPATCH_WIDTH-1:0]                           free_en,
    output logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] free_phys,
    input  logic [ARCH_REG_WIDTH-1:0]                           rd_arch,
    output logic [PHYS_REGS_ADDR_WIDTH-1:0]                     rd_phys,
    output logic [INSTRET_WIDTH-1:0]                            instret,
    output logic [PC_WIDTH-1:0]                                 last_pc,
    output logic                                                err_dup
);

    commit_lane_t                   lane [DISPATCH_WIDTH];

    phys_reg_t                      map_q [ARCH_REGS];
    phys_reg_t                      map_d [ARCH_REGS];
    logic      [DISPATCH_WIDTH-1:0] free_en_q, free_en_d;
    phys_reg_t                      free_phys_q [DISPATCH_WIDTH];
    phys_reg_t                      free_phys_d [DISPATCH_WIDTH];
    logic [INSTRET_WIDTH-1:0]       instret_q, instret_d;
    pc_t                            last_pc_q, last_pc_d;
    logic                           err_dup_q, err_dup_d;
    logic                           dup_hit;

    // Gather per-lane commit fields into the shared lane record.
    always_comb begin
        for (int w = 0; w < int'(DISPATCH_WIDTH); w++) begin
            lane[w].en      = commit_en[w];
            lane[w].phys_rd = commit_phys_rd[w];
            lane[w].arch_rd = commit_arch_rd[w];
            lane[w].pc      = commit_pc[w];
        end
    end

    // Apply lanes oldest-first so younger lanes see older lanes' writes (intra-group bypass).
    always_comb begin
        map_d       = map_q;
        free_en_d   = '0;
        free_phys_d = free_phys_q;
        last_pc_d   = last_pc_q;
        dup_hit     = 1'b0;
        for (int w = 0; w < int'(DISPATCH_WIDTH); w++) begin
            if (lane[w].en) begin
                last_pc_d = lane[w].pc;
            end
            if (lane[w].en && (lane[w].arch_rd != '0)) begin
                for (int j = 1; j < int'(ARCH_REGS); j++) begin
                    if ((ARCH_REG_WIDTH'(j) != lane[w].arch_rd) && (map_d[j] == lane[w].phys_rd)) begin
                        dup_hit = 1'b1;
                    end
                end
                free_en_d[w]             = 1'b1;
                free_phys_d[w]           = map_d[lane[w].arch_rd];
                map_d[lane[w].arch_rd]   = lane[w].phys_rd;
            end
        end
        map_d[0]  = '0;
        instret_d = instret_q + INSTRET_WIDTH'(popcount(commit_en));
        err_dup_d = err_dup_q | dup_hit;
    end

    // Committed state registers; reset restores the identity mapping and drops in-flight commits.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(ARCH_REGS); i++) begin
                map_q[i] <= PHYS_REGS_ADDR_WIDTH'(i);
            end
            free_en_q <= '0;
            for (int w = 0; w < int'(DISPATCH_WIDTH); w++) begin
                free_phys_q[w] <= '0;
            end
            instret_q <= '0;
            last_pc_q <= '0;
            err_dup_q <= 1'b0;
        end else begin
            map_q       <= map_d;
            free_en_q   <= free_en_d;
            free_phys_q <= free_phys_d;
            instret_q   <= instret_d;
            last_pc_q   <= last_pc_d;
            err_dup_q   <= err_dup_d;
        end
    end

    // Output drive; the read port looks at registered table state only.
    always_comb begin
        for (int w = 0; w < int'(DISPATCH_WIDTH); w++) begin
            free_phys[w] = free_phys_q[w];
        end
        rd_phys = (rd_arch == '0) ? '0 : map_q[rd_arch];
    end

    assign free_en = free_en_q;
    assign instret = instret_q;
    assign last_pc = last_pc_q;
    assign err_dup = err_dup_q;

endmodule

// File: tb/tb_retire_rat.sv
// Directed bench for retire_rat: reset map, single/dual commit, x0 lanes, duplicate detection, reset mid-commit.
module tb_retire_rat;
    import retire_rat_pkg::*;

    logic                                                clk;
    logic                                                rst;
    logic [DISPATCH_WIDTH-1:0]                           commit_en;
    logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] commit_phys_rd;
    logic [DISPATCH_WIDTH-1:0][ARCH_REG_WIDTH-1:0]       commit_arch_rd;
    logic [DISPATCH_WIDTH-1:0][PC_WIDTH-1:0]             commit_pc;
    logic [DISPATCH_WIDTH-1:0]                           free_en;
    logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] free_phys;
    logic [ARCH_REG_WIDTH-1:0]                           rd_arch;
    logic [PHYS_REGS_ADDR_WIDTH-1:0]                     rd_phys;
    logic [INSTRET_WIDTH-1:0]                            instret;
    logic [PC_WIDTH-1:0]                                 last_pc;
    logic                                                err_dup;

    int n_checks = 0;
    int n_fail   = 0;

    retire_rat dut (
        .clk            (clk),
        .rst            (rst),
        .commit_en      (commit_en),
        .commit_phys_rd (commit_phys_rd),
        .commit_arch_rd (commit_arch_rd),
        .commit_pc      (commit_pc),
        .free_en        (free_en),
        .free_phys      (free_phys),
        .rd_arch        (rd_arch),
        .rd_phys        (rd_phys),
        .instret        (instret),
        .last_pc        (last_pc),
        .err_dup        (err_dup)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one commit group on the falling edge, let it clock in, then idle the inputs.
    task automatic commit_cycle(input logic [1:0] en,
                                input int a0, input int p0, input logic [31:0] pc0,
                                input int a1, input int p1, input logic [31:0] pc1);
        @(negedge clk);
        commit_en         = en;
        commit_arch_rd[0] = 5'(a0);
        commit_phys_rd[0] = 6'(p0);
        commit_pc[0]      = pc0;
        commit_arch_rd[1] = 5'(a1);
        commit_phys_rd[1] = 6'(p1);
        commit_pc[1]      = pc1;
        @(posedge clk);
        #1;
        commit_en = '0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 32; i++) begin
            rd_arch = 5'(i);
            #1;
            n_checks++;
            if (rd_phys !== 6'(i)) begin
                n_fail++;
                $display("FAIL reset_map[%0d]: got %0d expected %0d", i, rd_phys, i);
            end
        end
        n_checks++;
        if (free_en !== 2'b00 || instret !== 64'd0 || err_dup !== 1'b0 || last_pc !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: free_en=%b instret=%0d err_dup=%b last_pc=%h expected 00/0/0/0",
                     free_en, instret, err_dup, last_pc);
        end
    endtask

    task automatic test_single_commit();
        commit_cycle(2'b01, 5, 40, 32'h0000_1000, 0, 0, 32'h0);
        rd_arch = 5'd5;
        #1;
        n_checks++;
        if (free_en !== 2'b01 || free_phys[0] !== 6'd5) begin
            n_fail++;
            $display("FAIL single_free: free_en=%b free_phys0=%0d expected 01/5", free_en, free_phys[0]);
        end
        n_checks++;
        if (rd_phys !== 6'd40) begin
            n_fail++;
            $display("FAIL single_map: got %0d expected 40", rd_phys);
        end
        n_checks++;
        if (instret !== 64'd1 || last_pc !== 32'h0000_1000) begin
            n_fail++;
            $display("FAIL single_cnt: instret=%0d last_pc=%h expected 1/00001000", instret, last_pc);
        end
    endtask

    task automatic test_same_arch_pair();
        commit_cycle(2'b11, 7, 41, 32'h0000_2000, 7, 42, 32'h0000_2004);
        rd_arch = 5'd7;
        #1;
        n_checks++;
        if (free_en !== 2'b11 || free_phys[0] !== 6'd7 || free_phys[1] !== 6'd41) begin
            n_fail++;
            $display("FAIL pair_free: free_en=%b fp0=%0d fp1=%0d expected 11/7/41",
                     free_en, free_phys[0], free_phys[1]);
        end
        n_checks++;
        if (rd_phys !== 6'd42) begin
            n_fail++;
            $display("FAIL pair_map: got %0d expected 42", rd_phys);
        end
        n_checks++;
        if (instret !== 64'd3 || last_pc !== 32'h0000_2004 || err_dup !== 1'b0) begin
            n_fail++;
            $display("FAIL pair_cnt: instret=%0d last_pc=%h err_dup=%b expected 3/00002004/0",
                     instret, last_pc, err_dup);
        end
    endtask

    task automatic test_x0_lane();
        commit_cycle(2'b11, 0, 50, 32'h0000_0100, 3, 51, 32'h0000_0104);
        rd_arch = 5'd0;
        #1;
        n_checks++;
        if (free_en !== 2'b10 || free_phys[1] !== 6'd3 || free_phys[0] !== 6'd7) begin
            n_fail++;
            $display("FAIL x0_free: free_en=%b fp0=%0d fp1=%0d expected 10/7(held)/3",
                     free_en, free_phys[0], free_phys[1]);
        end
        n_checks++;
        if (rd_phys !== 6'd0) begin
            n_fail++;
            $display("FAIL x0_map: got %0d expected 0", rd_phys);
        end
        rd_arch = 5'd3;
        #1;
        n_checks++;
        if (rd_phys !== 6'd51) begin
            n_fail++;
            $display("FAIL x0_lane1_map: got %0d expected 51", rd_phys);
        end
        n_checks++;
        if (instret !== 64'd5 || last_pc !== 32'h0000_0104) begin
            n_fail++;
            $display("FAIL x0_cnt: instret=%0d last_pc=%h expected 5/00000104", instret, last_pc);
        end
    endtask

    task automatic test_lane1_only_and_idle();
        commit_cycle(2'b10, 0, 0, 32'h0, 10, 52, 32'h0000_0300);
        rd_arch = 5'd10;
        #1;
        n_checks++;
        if (free_en !== 2'b10 || free_phys[1] !== 6'd10 || rd_phys !== 6'd52) begin
            n_fail++;
            $display("FAIL lane1_only: free_en=%b fp1=%0d map10=%0d expected 10/10/52",
                     free_en, free_phys[1], rd_phys);
        end
        n_checks++;
        if (instret !== 64'd6 || last_pc !== 32'h0000_0300) begin
            n_fail++;
            $display("FAIL lane1_cnt: instret=%0d last_pc=%h expected 6/00000300", instret, last_pc);
        end
        commit_cycle(2'b00, 11, 60, 32'hDEAD_BEEF, 12, 61, 32'hDEAD_BEEF);
        rd_arch = 5'd11;
        #1;
        n_checks++;
        if (free_en !== 2'b00 || instret !== 64'd6 || last_pc !== 32'h0000_0300 || rd_phys !== 6'd11) begin
            n_fail++;
            $display("FAIL idle: free_en=%b instret=%0d last_pc=%h map11=%0d expected 00/6/00000300/11",
                     free_en, instret, last_pc, rd_phys);
        end
    endtask

    task automatic test_dup();
        commit_cycle(2'b01, 9, 40, 32'h0000_0400, 0, 0, 32'h0);
        rd_arch = 5'd9;
        #1;
        n_checks++;
        if (err_dup !== 1'b1 || rd_phys !== 6'd40 || free_en !== 2'b01 || free_phys[0] !== 6'd9) begin
            n_fail++;
            $display("FAIL dup_set: err_dup=%b map9=%0d free_en=%b fp0=%0d expected 1/40/01/9",
                     err_dup, rd_phys, free_en, free_phys[0]);
        end
        commit_cycle(2'b00, 0, 0, 32'h0, 0, 0, 32'h0);
        commit_cycle(2'b01, 13, 62, 32'h0000_0500, 0, 0, 32'h0);
        n_checks++;
        if (err_dup !== 1'b1 || instret !== 64'd8) begin
            n_fail++;
            $display("FAIL dup_sticky: err_dup=%b instret=%0d expected 1/8", err_dup, instret);
        end
    endtask

    task automatic test_reset_mid_commit();
        @(negedge clk);
        rst               = 1'b1;
        commit_en         = 2'b11;
        commit_arch_rd[0] = 5'd4;
        commit_phys_rd[0] = 6'd55;
        commit_pc[0]      = 32'h0000_0600;
        commit_arch_rd[1] = 5'd6;
        commit_phys_rd[1] = 6'd56;
        commit_pc[1]      = 32'h0000_0604;
        @(posedge clk);
        #1;
        commit_en = '0;
        rst       = 1'b0;
        n_checks++;
        if (free_en !== 2'b00 || instret !== 64'd0 || err_dup !== 1'b0 || last_pc !== 32'd0
            || free_phys[0] !== 6'd0 || free_phys[1] !== 6'd0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: free_en=%b instret=%0d err_dup=%b last_pc=%h fp0=%0d fp1=%0d expected zeros",
                     free_en, instret, err_dup, last_pc, free_phys[0], free_phys[1]);
        end
        for (int i = 0; i < 32; i++) begin
            rd_arch = 5'(i);
            #1;
            n_checks++;
            if (rd_phys !== 6'(i)) begin
                n_fail++;
                $display("FAIL rst_mid_map[%0d]: got %0d expected %0d", i, rd_phys, i);
            end
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (free_en !== 2'b00 || instret !== 64'd0) begin
            n_fail++;
            $display("FAIL rst_mid_after: free_en=%b instret=%0d expected 00/0", free_en, instret);
        end
    endtask

    initial begin
        rst            = 1'b1;
        commit_en      = '0;
        commit_phys_rd = '0;
        commit_arch_rd = '0;
        commit_pc      = '0;
        rd_arch        = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        test_reset();
        test_single_commit();
        test_same_arch_pair();
        test_x0_lane();
        test_lane1_only_and_idle();
        test_dup();
        test_reset_mid_commit();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
